// File: rtl/register_bank_8x16.sv
// ---------------------------------------------------------------------------
// register_bank_8x16
//
// Eight WIDTH-bit registers with a single write port, a per-register dirty
// flag and a sequential "clear all" engine that zeroes one register per
// clock (0 through 7) and then pulses clr_done.
//
// The registers are kept in individual flops rather than a RAM array because
// all eight values have to be visible at once on q0..q7. Those outputs feed
// the data inputs of a downstream 8-to-1 select mux.
//
// Ports
//   clk        in   sole clock, rising edge
//   reset      in   synchronous, active-high reset
//   wr_valid   in   write request
//   wr_ready   out  1 while idle (a write can be accepted this cycle)
//   wr_addr    in   register index to write (0-7)
//   wr_data    in   write data
//   clr_start  in   start a sequential clear (ignored while a clear runs)
//   busy       out  clear sequence in progress (inverse of wr_ready)
//   clr_done   out  one-cycle pulse in the first idle cycle after a clear
//   q0..q7     out  register contents, straight from the storage flops
//   dirty      out  bit i set while register i holds data written since its
//                   last clear or reset
// ---------------------------------------------------------------------------
module register_bank_8x16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [2:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             clr_start,
    output logic             busy,
    output logic             clr_done,
    output logic [WIDTH-1:0] q0,
    output logic [WIDTH-1:0] q1,
    output logic [WIDTH-1:0] q2,
    output logic [WIDTH-1:0] q3,
    output logic [WIDTH-1:0] q4,
    output logic [WIDTH-1:0] q5,
    output logic [WIDTH-1:0] q6,
    output logic [WIDTH-1:0] q7,
    output logic [7:0]       dirty
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] CLEAR = 1'b1;

    logic [0:0]       state_reg;
    logic [2:0]       idx_reg;
    logic             clr_done_reg;
    logic             wr_accept;
    logic [WIDTH-1:0] data_q [8];

    // Handshake outputs depend only on the state flop.
    assign wr_ready  = (state_reg == IDLE);
    assign busy      = (state_reg == CLEAR);
    assign clr_done  = clr_done_reg;
    assign wr_accept = wr_valid && wr_ready;

    // -----------------------------------------------------------------------
    // Clear sequencer. A write that coincides with clr_start is still taken
    // in that same IDLE edge; the sequence then wipes it along with the rest.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            idx_reg      <= 3'd0;
            clr_done_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    clr_done_reg <= 1'b0;
                    if (clr_start) begin
                        state_reg <= CLEAR;
                        idx_reg   <= 3'd0;
                    end
                end
                default: begin
                    // clr_start is not looked at here, so a re-pulse can
                    // neither restart nor extend the sequence.
                    // The 3-bit index wraps 7 -> 0 on the final step.
                    idx_reg <= idx_reg + 3'd1;
                    if (idx_reg == 3'd7) begin
                        state_reg    <= IDLE;
                        clr_done_reg <= 1'b1;
                    end else begin
                        clr_done_reg <= 1'b0;
                    end
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Storage: one data register and one dirty flag per index. A write hit
    // and a clear hit can never coincide, because writes are only accepted
    // in IDLE and the clear hits only in CLEAR.
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_reg
            logic [WIDTH-1:0] data_reg;
            logic             dirty_reg;
            logic             clr_hit;
            logic             wr_hit;

            assign clr_hit = (state_reg == CLEAR) && (idx_reg == 3'(gi));
            assign wr_hit  = wr_accept && (wr_addr == 3'(gi));

            always_ff @(posedge clk) begin
                if (reset) begin
                    data_reg  <= '0;
                    dirty_reg <= 1'b0;
                end else if (clr_hit) begin
                    data_reg  <= '0;
                    dirty_reg <= 1'b0;
                end else if (wr_hit) begin
                    data_reg  <= wr_data;
                    dirty_reg <= 1'b1;
                end
            end

            assign data_q[gi] = data_reg;
            assign dirty[gi]  = dirty_reg;
        end
    endgenerate

    assign q0 = data_q[0];
    assign q1 = data_q[1];
    assign q2 = data_q[2];
    assign q3 = data_q[3];
    assign q4 = data_q[4];
    assign q5 = data_q[5];
    assign q6 = data_q[6];
    assign q7 = data_q[7];

endmodule

// File: tb/tb_register_bank_8x16.sv
// ---------------------------------------------------------------------------
// tb_register_bank_8x16
//
// Bench for register_bank_8x16. It runs directed scenarios and then a
// randomized run. Every clock edge is mirrored in a behavioural model that
// works from the architectural rules: array contents, a dirty mask, and a
// count of registers already cleared. After each edge all DUT outputs are
// compared with the model.
// ---------------------------------------------------------------------------
module tb_register_bank_8x16;

    logic        clk;
    logic        reset;
    logic        wr_valid;
    logic        wr_ready;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic        clr_start;
    logic        busy;
    logic        clr_done;
    logic [15:0] q [8];
    logic [7:0]  dirty;

    int n_tests;
    int n_fail;

    // Reference model state.
    logic [15:0] m_val [8];
    logic [7:0]  m_dirty;
    bit          m_clearing;
    int          m_cleared;   // number of registers already zeroed this run
    bit          m_done;

    register_bank_8x16 #(.WIDTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .clr_start (clr_start),
        .busy      (busy),
        .clr_done  (clr_done),
        .q0        (q[0]),
        .q1        (q[1]),
        .q2        (q[2]),
        .q3        (q[3]),
        .q4        (q[4]),
        .q5        (q[5]),
        .q6        (q[6]),
        .q7        (q[7]),
        .dirty     (dirty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Apply the inputs currently on the bus to the model, as one edge would.
    task automatic model_step();
        if (reset) begin
            for (int i = 0; i < 8; i++) m_val[i] = 16'h0000;
            m_dirty    = 8'h00;
            m_clearing = 1'b0;
            m_cleared  = 0;
            m_done     = 1'b0;
        end else if (!m_clearing) begin
            m_done = 1'b0;
            if (wr_valid) begin
                m_val[wr_addr]   = wr_data;
                m_dirty[wr_addr] = 1'b1;
            end
            if (clr_start) begin
                m_clearing = 1'b1;
                m_cleared  = 0;
            end
        end else begin
            m_val[m_cleared]   = 16'h0000;
            m_dirty[m_cleared] = 1'b0;
            m_cleared++;
            m_done = (m_cleared == 8);
            if (m_cleared == 8) m_clearing = 1'b0;
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 8; i++) check($sformatf("q%0d", i), 32'(q[i]), 32'(m_val[i]));
        check("dirty", 32'(dirty), 32'(m_dirty));
        check("wr_ready", 32'(wr_ready), 32'(!m_clearing));
        check("busy", 32'(busy), 32'(m_clearing));
        check("clr_done", 32'(clr_done), 32'(m_done));
    endtask

    // One clock: the edge samples the current inputs, then the outputs are
    // checked 1 ns later and a transaction line is printed.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        $display("[TB] t=%0t rst=%0b wv=%0b wa=%0d wd=%h cs=%0b -> rdy=%0b busy=%0b done=%0b dirty=%h",
                 $time, reset, wr_valid, wr_addr, wr_data, clr_start,
                 wr_ready, busy, clr_done, dirty);
    endtask

    task automatic idle_inputs();
        reset     = 1'b0;
        wr_valid  = 1'b0;
        wr_addr   = 3'd0;
        wr_data   = 16'h0000;
        clr_start = 1'b0;
    endtask

    task automatic write(input logic [2:0] a, input logic [15:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        cycle();
        wr_valid = 1'b0;
    endtask

    task automatic preload(input logic [15:0] base, input bit scale);
        for (int i = 0; i < 8; i++) write(3'(i), scale ? 16'(base * (i + 1)) : base);
    endtask

    // Runs until busy drops, within a bound. Returns the busy-cycle count and
    // the number of clr_done pulses seen, counting the current sample.
    task automatic run_clear(output int busy_cycles, output int done_pulses);
        busy_cycles = 0;
        done_pulses = 0;
        for (int k = 0; k < 20 && busy; k++) begin
            busy_cycles++;
            cycle();
            if (clr_done) done_pulses++;
        end
        check("clear_timeout", 32'(busy), 32'd0);
    endtask

    int bc;
    int dp;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < 8; i++) m_val[i] = 16'hxxxx;
        m_dirty    = 8'hxx;
        m_clearing = 1'b0;
        m_cleared  = 0;
        m_done     = 1'b0;
        idle_inputs();

        // Reset state.
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
        check("rst_ready", 32'(wr_ready), 32'd1);
        check("rst_dirty", 32'(dirty), 32'h00);

        // Single write to addr 3.
        write(3'd3, 16'hA5A5);
        check("w3_q3", 32'(q[3]), 32'hA5A5);
        check("w3_dirty", 32'(dirty), 32'h08);

        // Fill all registers, then clear them.
        preload(16'h1111, 1'b1);
        check("fill_q7", 32'(q[7]), 32'h8888);
        check("fill_dirty", 32'(dirty), 32'hFF);
        clr_start = 1'b1;
        cycle();
        clr_start = 1'b0;
        run_clear(bc, dp);
        check("clr_busy_len", 32'(bc), 32'd8);
        check("clr_done_cnt", 32'(dp), 32'd1);
        check("clr_dirty", 32'(dirty), 32'h00);

        // Write held through CLEAR, accepted on the clr_done cycle.
        preload(16'h2222, 1'b0);
        clr_start = 1'b1;
        cycle();
        clr_start = 1'b0;
        wr_valid  = 1'b1;
        wr_addr   = 3'd5;
        wr_data   = 16'hBEEF;
        bc = 0;
        for (int k = 0; k < 20; k++) begin
            automatic bit was_ready = wr_ready;
            if (clr_done) check("held_accept_on_done", 32'(wr_ready), 32'd1);
            cycle();
            bc++;
            if (was_ready) break;
        end
        wr_valid = 1'b0;
        check("held_cycles", 32'(bc), 32'd9);
        check("held_q5", 32'(q[5]), 32'hBEEF);
        cycle();

        // clr_start together with a write to addr 7.
        wr_valid  = 1'b1;
        wr_addr   = 3'd7;
        wr_data   = 16'h00FF;
        clr_start = 1'b1;
        cycle();
        idle_inputs();
        check("co_q7", 32'(q[7]), 32'h00FF);
        check("co_busy", 32'(busy), 32'd1);
        run_clear(bc, dp);
        check("co_q7_zero", 32'(q[7]), 32'h0000);
        check("co_len", 32'(bc), 32'd8);

        // Reset on the 4th CLEAR cycle.
        preload(16'hFFFF, 1'b0);
        clr_start = 1'b1;
        cycle();
        clr_start = 1'b0;
        cycle();
        cycle();
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("rstclr_busy", 32'(busy), 32'd0);
        check("rstclr_dirty", 32'(dirty), 32'h00);
        check("rstclr_q0", 32'(q[0]), 32'h0000);
        cycle();
        check("rstclr_nodone", 32'(clr_done), 32'd0);

        // clr_start re-pulsed mid-CLEAR.
        preload(16'h0101, 1'b1);
        clr_start = 1'b1;
        cycle();
        clr_start = 1'b0;
        cycle();
        cycle();
        clr_start = 1'b1;
        cycle();
        clr_start = 1'b0;
        run_clear(bc, dp);
        check("repulse_len", 32'(bc + 3), 32'd8);
        check("repulse_done", 32'(dp), 32'd1);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            reset     = ($urandom_range(0, 99) == 0);
            wr_valid  = ($urandom_range(0, 2) != 0);
            wr_addr   = 3'($urandom);
            wr_data   = 16'($urandom);
            clr_start = ($urandom_range(0, 19) == 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/register_bank_8x16.md
REGISTER_BANK_8X16 -- requirements
Module: register_bank_8x16

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the data width of each register.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port wr_valid  input  1  write request.
REQ-005 SHALL have port wr_ready  output  1  bank can accept a write this cycle.
REQ-006 SHALL have port wr_addr  input  3  register index to write (0-7).
REQ-007 SHALL have port wr_data  input  WIDTH  write data.
REQ-008 SHALL have port clr_start  input  1  request to start a sequential clear of all registers.
REQ-009 SHALL have port busy  output  1  clear sequence in progress.
REQ-010 SHALL have port clr_done  output  1  one-cycle pulse when a clear sequence completes.
REQ-011 SHALL have ports q0..q7  output  WIDTH each  current contents of registers 0-7, driven directly to the downstream 8-to-1 select mux data inputs d0..d7.
REQ-012 SHALL have port dirty  output  8  bit i set while register i holds a value written since its last clear or reset.

Function
REQ-013 SHALL implement an FSM with two states: IDLE and CLEAR.
REQ-014 SHALL drive q0..q7 straight from storage flops, with no combinational path from any input.
REQ-015 SHALL drive wr_ready = 1 in IDLE and 0 in CLEAR; busy = inverse of wr_ready; both decoded from the state register only.
REQ-016 SHALL accept a write at a rising edge when wr_valid && wr_ready: reg[wr_addr] <= wr_data, dirty[wr_addr] <= 1.
REQ-017 SHALL make written data visible on the matching q output on the cycle after acceptance (1-cycle latency); other registers unchanged.
REQ-018 SHALL NOT modify any register or dirty bit when wr_valid = 1 and wr_ready = 0; upstream holds the request until accepted.
REQ-019 SHALL move IDLE -> CLEAR on an edge where clr_start = 1 in IDLE, with clear index set to 0.
REQ-020 SHALL, when clr_start and an accepted write coincide in IDLE, perform the write, then enter CLEAR; the write is later zeroed by the sequence.
REQ-021 SHALL, on each edge in CLEAR, set reg[index] <= 0 and dirty[index] <= 0, then increment the 3-bit index.
REQ-022 SHALL clear registers in order 0..7, taking exactly 8 cycles in CLEAR; busy = 1 for exactly those 8 cycles.
REQ-023 SHALL, on the edge that clears register 7, wrap the index to 0, return to IDLE and register clr_done = 1 for exactly one cycle.
REQ-024 SHALL leave not-yet-cleared registers readable with their old values on q during CLEAR.
REQ-025 SHALL ignore clr_start while in CLEAR (no restart, no extension).
REQ-026 SHALL accept a write on the first IDLE cycle after CLEAR, i.e. the cycle clr_done = 1.

Reset
REQ-027 SHALL, on an edge with reset = 1, set all registers to 0, dirty = 8'h00, state = IDLE, index = 0, clr_done = 0, giving wr_ready = 1 and busy = 0.
REQ-028 SHALL give reset priority over write and clear; reset during CLEAR aborts the sequence with no clr_done pulse.

Verification
REQ-029 SHALL be verified by: write 16'hA5A5 to addr 3 -> next cycle q3 = 16'hA5A5, dirty = 8'h08, other q = 0.
REQ-030 SHALL be verified by: write all 8 registers with 16'h1111*(i+1), pulse clr_start -> busy high 8 cycles, q0..q7 zeroed one per cycle in order 0..7, clr_done pulses once as busy falls, dirty = 8'h00.
REQ-031 SHALL be verified by: wr_valid held with addr 5, data 16'hBEEF during CLEAR -> no change while busy; accepted on the clr_done cycle, q5 = 16'hBEEF one cycle later.
REQ-032 SHALL be verified by: clr_start and write of 16'h00FF to addr 7 in the same IDLE cycle -> q7 = 16'h00FF after 1 cycle, 0 after the eighth clear cycle.
REQ-033 SHALL be verified by: reset asserted on the 4th CLEAR cycle with registers preloaded to 16'hFFFF -> next cycle all q = 0, dirty = 0, busy = 0, wr_ready = 1, no clr_done pulse.
REQ-034 SHALL be verified by: clr_start re-pulsed mid-CLEAR -> sequence still ends after exactly 8 cycles with a single clr_done pulse.
